// File: rtl/ushift_reg_enable_if.sv
// Bus bundle for the universal shift register: control/data inputs and
// register/status outputs. clk and rst_n stay as plain ports on the design.
// Optional macro USHIFT_ROTATE_EN adds the rot control line.
interface ushift_reg_enable_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             si_r;
  logic             si_l;
  logic             start;
  logic [CNTW-1:0]  shamt;
`ifdef USHIFT_ROTATE_EN
  logic             rot;
`endif
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             so_r;
  logic             so_l;
  logic             busy;
  logic             done;

  modport master (
`ifdef USHIFT_ROTATE_EN
    output rot,
`endif
    output en, mode, d, si_r, si_l, start, shamt,
    input  q, q_n, so_r, so_l, busy, done
  );

  modport slave (
`ifdef USHIFT_ROTATE_EN
    input  rot,
`endif
    input  en, mode, d, si_r, si_l, start, shamt,
    output q, q_n, so_r, so_l, busy, done
  );
endinterface

// File: rtl/ushift_reg_enable.sv
// Universal shift register: hold, single-step shift left/right, parallel
// load and a counted burst-shift engine with busy/done status.
// Optional macro USHIFT_ROTATE_EN: rot input turns shifts into rotates
// (latched at burst start for the whole burst).
module ushift_reg_enable #(
  parameter int               WIDTH   = 8,
  parameter int               CNTW    = $clog2(WIDTH + 1),
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic                clk,
  input logic                rst_n,
  ushift_reg_enable_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [CNTW-1:0] WIDTH_C = CNTW'(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] q;
  logic [CNTW-1:0]  cnt;
  logic             dir_left;
  logic             rot_lat;
  logic             rot_in;
  logic             rot_now;
  logic             burst_go;
  logic [CNTW-1:0]  shamt_clamped;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] shl_val;

`ifdef USHIFT_ROTATE_EN
  assign rot_in = bus.rot;
`else
  assign rot_in = 1'b0;
`endif

  // Burst request decode, shift-amount clamp and both candidate shift results
  always_comb begin
    burst_go      = (state == IDLE) && bus.en && bus.start &&
                    ((bus.mode == 2'b01) || (bus.mode == 2'b10));
    shamt_clamped = (bus.shamt > WIDTH_C) ? WIDTH_C : bus.shamt;
    rot_now       = (state == SHIFT) ? rot_lat : rot_in;
    shr_val       = {(rot_now ? q[0] : bus.si_r), q[WIDTH-1:1]};
    shl_val       = {q[WIDTH-2:0], (rot_now ? q[WIDTH-1] : bus.si_l)};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; DONE always falls back to IDLE, even with en low
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (burst_go) state_next = (shamt_clamped != '0) ? SHIFT : DONE;
      SHIFT:   if (bus.en && (cnt <= CNTW'(1))) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state register
  always_comb begin
    bus.busy = (state == SHIFT);
    bus.done = (state == DONE);
  end

  // Datapath: register, burst counter and latched burst direction/rotate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= RST_VAL;
      cnt      <= '0;
      dir_left <= 1'b0;
      rot_lat  <= 1'b0;
    end else if (bus.en) begin
      case (state)
        IDLE: begin
          if (burst_go) begin
            cnt      <= shamt_clamped;
            dir_left <= (bus.mode == 2'b10);
            rot_lat  <= rot_in;
          end else begin
            case (bus.mode)
              2'b01:   q <= shr_val;
              2'b10:   q <= shl_val;
              2'b11:   q <= bus.d;
              default: q <= q;
            endcase
          end
        end
        SHIFT: begin
          q   <= dir_left ? shl_val : shr_val;
          cnt <= cnt - CNTW'(1);
        end
        default: q <= q;
      endcase
    end
  end

  assign bus.q    = q;
  assign bus.q_n  = ~q;
  assign bus.so_r = q[0];
  assign bus.so_l = q[WIDTH-1];

endmodule

// File: tb/tb_ushift_reg_enable.sv
// Testbench for ushift_reg_enable: directed cases plus randomized traffic,
// checked by a queue-based scoreboard against a behavioural model.
module tb_ushift_reg_enable;
  localparam int WIDTH = 8;
  localparam int CNTW  = $clog2(WIDTH + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ushift_reg_enable_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  ushift_reg_enable #(.WIDTH(WIDTH), .CNTW(CNTW), .RST_VAL('0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: register value, remaining burst shifts, pending done
  logic [WIDTH-1:0] m_q;
  bit               m_burst;
  int               m_left;
  bit               m_dir_left;
  bit               m_rot;
  bit               m_done;

  task automatic check_vec(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] v, input bit left,
                                               input bit serial_in, input bit rot);
    bit incoming;
    if (left) begin
      incoming = rot ? v[WIDTH-1] : serial_in;
      return (v << 1) | WIDTH'(incoming);
    end
    incoming = rot ? v[0] : serial_in;
    return (v >> 1) | (WIDTH'(incoming) << (WIDTH - 1));
  endfunction

  task automatic model_reset();
    m_q = '0; m_burst = 0; m_left = 0; m_dir_left = 0; m_rot = 0; m_done = 0;
  endtask

  task automatic model_step(input bit en, input bit [1:0] mode, input logic [WIDTH-1:0] d,
                            input bit sir, input bit sil, input bit start, input int shamt,
                            input bit rot);
    int n;
    if (m_done) begin
      m_done = 0;
      return;
    end
    if (!en) return;
    if (m_burst) begin
      m_q = shifted(m_q, m_dir_left, m_dir_left ? sil : sir, m_rot);
      m_left--;
      if (m_left == 0) begin
        m_burst = 0;
        m_done  = 1;
      end
      return;
    end
    if (start && (mode == 2'd1 || mode == 2'd2)) begin
      n          = (shamt > WIDTH) ? WIDTH : shamt;
      m_dir_left = (mode == 2'd2);
      m_rot      = rot;
      if (n == 0) m_done = 1;
      else begin
        m_burst = 1;
        m_left  = n;
      end
    end else begin
      case (mode)
        2'd1:    m_q = shifted(m_q, 0, sir, rot);
        2'd2:    m_q = shifted(m_q, 1, sil, rot);
        2'd3:    m_q = d;
        default: ;
      endcase
    end
  endtask

  task automatic apply_stimulus(input bit en, input bit [1:0] mode, input logic [WIDTH-1:0] d,
                                input bit sir, input bit sil, input bit start, input int shamt,
                                input bit rot);
    bit rot_eff;
    @(negedge clk);
    bus.en    = en;
    bus.mode  = mode;
    bus.d     = d;
    bus.si_r  = sir;
    bus.si_l  = sil;
    bus.start = start;
    bus.shamt = CNTW'(shamt);
`ifdef USHIFT_ROTATE_EN
    bus.rot = rot;
    rot_eff = rot;
`else
    rot_eff = 1'b0;
`endif
    model_step(en, mode, d, sir, sil, start, shamt, rot_eff);
    exp_q.push_back('{q: m_q, busy: m_burst, done: m_done});
  endtask

  task automatic idle_cycles(input int n, input bit sir, input bit sil);
    for (int i = 0; i < n; i++) apply_stimulus(1, 2'd0, '0, sir, sil, 0, 0, 0);
  endtask

  task automatic check_output(input exp_t e);
    check_vec("q", bus.q, e.q);
    check_vec("q_n", bus.q_n, ~e.q);
    check_bit("so_r", bus.so_r, e.q[0]);
    check_bit("so_l", bus.so_l, e.q[WIDTH-1]);
    check_bit("busy", bus.busy, e.busy);
    check_bit("done", bus.done, e.done);
  endtask

  // Monitor: one expected entry per clock edge, compared shortly after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  task automatic check_after_edge(input string name, input logic [WIDTH-1:0] req);
    @(posedge clk);
    #2;
    check_vec(name, bus.q, req);
  endtask

  initial begin
    bus.en = 0; bus.mode = 0; bus.d = '0; bus.si_r = 0; bus.si_l = 0;
    bus.start = 0; bus.shamt = '0;
`ifdef USHIFT_ROTATE_EN
    bus.rot = 0;
`endif
    model_reset();
    #1;
    check_vec("reset_q", bus.q, 8'h00);
    check_vec("reset_q_n", bus.q_n, 8'hFF);
    check_bit("reset_busy", bus.busy, 1'b0);
    check_bit("reset_done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load then single right shift with si_r=1
    apply_stimulus(1, 2'd3, 8'hA5, 0, 0, 0, 0, 0);
    apply_stimulus(1, 2'd1, 8'h00, 1, 0, 0, 0, 0);
    check_after_edge("load_shift_q", 8'hD2);
    check_bit("load_shift_so_r", bus.so_r, 1'b0);

    // Burst left by 3 from 81
    apply_stimulus(1, 2'd3, 8'h81, 0, 0, 0, 0, 0);
    apply_stimulus(1, 2'd2, 8'h00, 0, 0, 1, 3, 0);
    idle_cycles(5, 0, 0);
    check_after_edge("burst_left_q", 8'h08);

    // Same burst with en low for two cycles mid-burst
    apply_stimulus(1, 2'd3, 8'h81, 0, 0, 0, 0, 0);
    apply_stimulus(1, 2'd2, 8'h00, 0, 0, 1, 3, 0);
    apply_stimulus(1, 2'd0, 8'h00, 0, 0, 0, 0, 0);
    apply_stimulus(0, 2'd3, 8'hFF, 1, 1, 1, 7, 0);
    apply_stimulus(0, 2'd1, 8'hFF, 1, 1, 0, 0, 0);
    idle_cycles(4, 0, 0);
    check_after_edge("burst_gap_q", 8'h08);

    // Zero-length burst, then an over-length burst filling with ones
    apply_stimulus(1, 2'd1, 8'h00, 1, 0, 1, 0, 0);
    idle_cycles(2, 0, 0);
    apply_stimulus(1, 2'd3, 8'h3C, 0, 0, 0, 0, 0);
    apply_stimulus(1, 2'd1, 8'h00, 1, 0, 1, 15, 0);
    idle_cycles(10, 1, 0);
    check_after_edge("burst_clamp_q", 8'hFF);

`ifdef USHIFT_ROTATE_EN
    apply_stimulus(1, 2'd3, 8'h81, 0, 0, 0, 0, 0);
    apply_stimulus(1, 2'd1, 8'h00, 0, 0, 1, 1, 1);
    idle_cycles(3, 0, 0);
    check_after_edge("rotate_q", 8'hC0);
`endif

    // Asynchronous reset in the middle of a 4-shift burst
    apply_stimulus(1, 2'd3, 8'hAA, 0, 0, 0, 0, 0);
    apply_stimulus(1, 2'd1, 8'h00, 1, 0, 1, 4, 0);
    apply_stimulus(1, 2'd0, 8'h00, 1, 0, 0, 0, 0);
    apply_stimulus(1, 2'd0, 8'h00, 1, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_vec("midreset_q", bus.q, 8'h00);
    check_vec("midreset_q_n", bus.q_n, 8'hFF);
    check_bit("midreset_busy", bus.busy, 1'b0);
    check_bit("midreset_done", bus.done, 1'b0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3, 1, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
                     WIDTH'($urandom), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 4) == 0), $urandom_range(0, 15), 1'($urandom));
    end

    @(posedge clk);
    #2;
    check_bit("queue_drained", (exp_q.size() == 0), 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
